bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Arbitrates the shared system bus between the CPU and two
//            secondary masters (master0 = PRC, master1 = DMA). The arbiter
//            asks the CPU to release the bus (bus_request / bus_ack), hands
//            the bus to one master at a time with round-robin tie breaking,
//            inserts idle turnaround cycles between masters and flags hold
//            timeouts and CPU handshake violations.
// Ports    : clk, reset (async, active low)
//            m_req/m_gnt            - per-master request / one-hot grant
//            m_address, m_data_out,
//            m_read, m_write,
//            m_bus_status           - packed master bus signals
//            cpu_*                  - CPU bus signals
//            bus_request / bus_ack  - hold handshake with the CPU
//            address_out, data_out,
//            read, write,
//            bus_status             - muxed system bus
//            owner                  - 0=CPU, 1=master0, 2=master1, 3=idle bus
//            hold_timeout,
//            protocol_error         - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int         TURNAROUND = 1,
    parameter int         MAX_HOLD   = 1024,
    parameter logic [1:0] BUS_IDLE   = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m_req,
    output logic [1:0]  m_gnt,
    input  logic [47:0] m_address,
    input  logic [15:0] m_data_out,
    input  logic [1:0]  m_read,
    input  logic [1:0]  m_write,
    input  logic [3:0]  m_bus_status,
    input  logic [23:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_bus_status,
    output logic        bus_request,
    input  logic        bus_ack,
    output logic [23:0] address_out,
    output logic [7:0]  data_out,
    output logic        read,
    output logic        write,
    output logic [1:0]  bus_status,
    output logic [1:0]  owner,
    output logic        hold_timeout,
    output logic        protocol_error
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_REQUEST = 3'd1;
    localparam logic [2:0] c_ST_GRANT   = 3'd2;
    localparam logic [2:0] c_ST_TURN    = 3'd3;
    localparam logic [2:0] c_ST_RELEASE = 3'd4;

    // TURN is entered with the number of remaining cycles minus one, so the
    // decision is taken on the edge that ends the last turnaround cycle.
    localparam bit         c_NO_TURN        = (TURNAROUND == 0);
    localparam logic [2:0] c_TURN_LOAD      = (TURNAROUND > 0) ? 3'(TURNAROUND - 1) : 3'd0;
    // The first GRANT cycle already counts as one held cycle.
    localparam bit         c_TIMEOUT_AT_ONE = (MAX_HOLD <= 1);

    logic [2:0]  r_state;
    logic [1:0]  r_gnt;
    logic        r_cur;            // master currently (or most recently) owning the bus
    logic        r_last;           // master served last, for round-robin ties
    logic [15:0] r_hold_cnt;
    logic [2:0]  r_turn_left;
    logic        r_hold_timeout;
    logic        r_protocol_error;

    logic        w_other;
    logic        w_pick;
    logic        w_grant_now;
    logic        w_grant_sel;
    logic [15:0] w_hold_inc;

    assign w_other    = ~r_cur;
    // Tie: the master not served last wins. Single requester: it wins.
    assign w_pick     = (m_req == 2'b11) ? ~r_last : m_req[1];
    assign w_hold_inc = (r_hold_cnt == 16'hFFFF) ? r_hold_cnt : r_hold_cnt + 16'd1;

    // Every way of starting a new grant funnels through here so the grant
    // bookkeeping lives in one place in the sequential block.
    always_comb begin
        w_grant_now = 1'b0;
        w_grant_sel = r_cur;
        case (r_state)
            c_ST_REQUEST: begin
                if ((m_req != 2'b00) && bus_ack) begin
                    w_grant_now = 1'b1;
                    w_grant_sel = w_pick;
                end
            end
            c_ST_GRANT: begin
                if (c_NO_TURN && bus_ack && !m_req[r_cur] && m_req[w_other]) begin
                    w_grant_now = 1'b1;
                    w_grant_sel = w_other;
                end
            end
            c_ST_TURN: begin
                if (bus_ack && (r_turn_left == 3'd0) && m_req[w_other]) begin
                    w_grant_now = 1'b1;
                    w_grant_sel = w_other;
                end
            end
            default: begin
                w_grant_now = 1'b0;
                w_grant_sel = r_cur;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= c_ST_IDLE;
            r_gnt            <= 2'b00;
            r_cur            <= 1'b0;
            r_last           <= 1'b1;
            r_hold_cnt       <= 16'd0;
            r_turn_left      <= 3'd0;
            r_hold_timeout   <= 1'b0;
            r_protocol_error <= 1'b0;
        end else if (w_grant_now) begin
            r_state    <= c_ST_GRANT;
            r_gnt      <= w_grant_sel ? 2'b10 : 2'b01;
            r_cur      <= w_grant_sel;
            r_last     <= w_grant_sel;
            r_hold_cnt <= 16'd1;
            if (c_TIMEOUT_AT_ONE) begin
                r_hold_timeout <= 1'b1;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (m_req != 2'b00) begin
                        r_state <= c_ST_REQUEST;
                    end
                end
                c_ST_REQUEST: begin
                    // Requests withdrawn before the CPU let go of the bus.
                    if (m_req == 2'b00) begin
                        r_state <= c_ST_RELEASE;
                    end
                end
                c_ST_GRANT: begin
                    if (!bus_ack) begin
                        r_state          <= c_ST_IDLE;
                        r_gnt            <= 2'b00;
                        r_protocol_error <= 1'b1;
                    end else if (!m_req[r_cur]) begin
                        r_gnt <= 2'b00;
                        if (c_NO_TURN) begin
                            r_state <= c_ST_RELEASE;
                        end else begin
                            r_state     <= c_ST_TURN;
                            r_turn_left <= c_TURN_LOAD;
                        end
                    end else begin
                        // Timeout is informational only; the owner keeps the bus.
                        r_hold_cnt <= w_hold_inc;
                        if (32'(w_hold_inc) >= 32'(MAX_HOLD)) begin
                            r_hold_timeout <= 1'b1;
                        end
                    end
                end
                c_ST_TURN: begin
                    if (!bus_ack) begin
                        r_state          <= c_ST_IDLE;
                        r_protocol_error <= 1'b1;
                    end else if (r_turn_left == 3'd0) begin
                        r_state <= c_ST_RELEASE;
                    end else begin
                        r_turn_left <= r_turn_left - 3'd1;
                    end
                end
                c_ST_RELEASE: begin
                    // New requests wait here until the CPU has taken the bus back.
                    if (!bus_ack) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

    // Gating with bus_ack guarantees no grant is ever visible while the CPU
    // is not acknowledging, even in the cycle before the FSM reacts.
    assign m_gnt          = r_gnt & {2{bus_ack}};
    assign bus_request    = (r_state == c_ST_REQUEST) || (r_state == c_ST_GRANT) ||
                            (r_state == c_ST_TURN);
    assign hold_timeout   = r_hold_timeout;
    assign protocol_error = r_protocol_error;

    always_comb begin
        address_out = cpu_address;
        data_out    = cpu_data_out;
        read        = cpu_read;
        write       = cpu_write;
        bus_status  = cpu_bus_status;
        owner       = 2'd0;
        case (r_state)
            c_ST_GRANT: begin
                if (r_cur) begin
                    address_out = m_address[47:24];
                    data_out    = m_data_out[15:8];
                    read        = m_read[1];
                    write       = m_write[1];
                    bus_status  = m_bus_status[3:2];
                    owner       = 2'd2;
                end else begin
                    address_out = m_address[23:0];
                    data_out    = m_data_out[7:0];
                    read        = m_read[0];
                    write       = m_write[0];
                    bus_status  = m_bus_status[1:0];
                    owner       = 2'd1;
                end
            end
            c_ST_TURN: begin
                // Nobody drives the bus during turnaround.
                address_out = 24'd0;
                data_out    = 8'd0;
                read        = 1'b0;
                write       = 1'b0;
                bus_status  = BUS_IDLE;
                owner       = 2'd3;
            end
            default: begin
                owner = 2'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Self-checking bench for bus_arbiter: directed scenarios for the
//            handshake, round-robin, turnaround, release, hold timeout,
//            protocol error and asynchronous reset, plus a randomized run
//            compared against a behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int         TA   = 1;
    localparam int         MAXH = 1024;
    localparam logic [1:0] BI   = 2'b00;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_req;
    logic [1:0]  m_gnt;
    logic [47:0] m_address;
    logic [15:0] m_data_out;
    logic [1:0]  m_read;
    logic [1:0]  m_write;
    logic [3:0]  m_bus_status;
    logic [23:0] cpu_address;
    logic [7:0]  cpu_data_out;
    logic        cpu_read;
    logic        cpu_write;
    logic [1:0]  cpu_bus_status;
    logic        bus_request;
    logic        bus_ack;
    logic [23:0] address_out;
    logic [7:0]  data_out;
    logic        read;
    logic        write;
    logic [1:0]  bus_status;
    logic [1:0]  owner;
    logic        hold_timeout;
    logic        protocol_error;

    int n_asserts = 0;
    int n_fail    = 0;

    bus_arbiter #(
        .TURNAROUND (TA),
        .MAX_HOLD   (MAXH),
        .BUS_IDLE   (BI)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m_req          (m_req),
        .m_gnt          (m_gnt),
        .m_address      (m_address),
        .m_data_out     (m_data_out),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_bus_status   (m_bus_status),
        .cpu_address    (cpu_address),
        .cpu_data_out   (cpu_data_out),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_bus_status (cpu_bus_status),
        .bus_request    (bus_request),
        .bus_ack        (bus_ack),
        .address_out    (address_out),
        .data_out       (data_out),
        .read           (read),
        .write          (write),
        .bus_status     (bus_status),
        .owner          (owner),
        .hold_timeout   (hold_timeout),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic rand_bus();
        m_address      = {$urandom, $urandom};
        m_data_out     = 16'($urandom);
        m_read         = 2'($urandom);
        m_write        = 2'($urandom);
        m_bus_status   = 4'($urandom);
        cpu_address    = 24'($urandom);
        cpu_data_out   = 8'($urandom);
        cpu_read       = 1'($urandom);
        cpu_write      = 1'($urandom);
        cpu_bus_status = 2'($urandom);
    endtask

    // Leaves the DUT out of reset right after a falling clock edge.
    task automatic do_reset();
        reset   = 1'b0;
        m_req   = 2'b00;
        bus_ack = 1'b0;
        rand_bus();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        m_req   = 2'b11;
        bus_ack = 1'b1;
        rand_bus();
        @(negedge clk);
        #1;
        n_asserts++;
        if ({m_gnt, bus_request, owner, hold_timeout, protocol_error} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got gnt=%b req=%b own=%0d to=%b pe=%b, expected all zero",
                     m_gnt, bus_request, owner, hold_timeout, protocol_error);
        end
        n_asserts++;
        if ({address_out, data_out, read, write, bus_status} !==
            {cpu_address, cpu_data_out, cpu_read, cpu_write, cpu_bus_status}) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h data=%h, expected cpu addr=%h data=%h",
                     address_out, data_out, cpu_address, cpu_data_out);
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        m_req = 2'b01;
        @(negedge clk);
        #1;
        n_asserts++;
        if ({bus_request, m_gnt} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_request: got req=%b gnt=%b, expected req=1 gnt=00", bus_request, m_gnt);
        end
        repeat (2) @(negedge clk);
        bus_ack = 1'b1;
        #1;
        n_asserts++;
        if (m_gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL single_early_gnt: got %b expected 00", m_gnt);
        end
        @(negedge clk);
        rand_bus();
        #1;
        n_asserts++;
        if ({m_gnt, owner, address_out, data_out} !== {2'b01, 2'd1, m_address[23:0], m_data_out[7:0]}) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b own=%0d addr=%h, expected gnt=01 own=1 addr=%h",
                     m_gnt, owner, address_out, m_address[23:0]);
        end
        m_req = 2'b00;
        @(negedge clk);
        #1;
        n_asserts++;
        if ({owner, m_gnt, bus_request} !== {2'd3, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL single_turn: got own=%0d gnt=%b req=%b, expected own=3 gnt=00 req=1",
                     owner, m_gnt, bus_request);
        end
        @(negedge clk);
        #1;
        n_asserts++;
        if ({bus_request, owner, address_out} !== {1'b0, 2'd0, cpu_address}) begin
            n_fail++;
            $display("FAIL release_entry: got req=%b own=%0d addr=%h, expected req=0 own=0 addr=%h",
                     bus_request, owner, address_out, cpu_address);
        end
        m_req = 2'b10;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            n_asserts++;
            if ({bus_request, m_gnt} !== 3'b000) begin
                n_fail++;
                $display("FAIL release_hold%0d: got req=%b gnt=%b, expected req=0 gnt=00", k, bus_request, m_gnt);
            end
        end
        bus_ack = 1'b0;
        @(negedge clk);
        #1;
        n_asserts++;
        if (bus_request !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle: got req=%b expected 0", bus_request);
        end
        @(negedge clk);
        #1;
        n_asserts++;
        if (bus_request !== 1'b1) begin
            n_fail++;
            $display("FAIL after_idle_request: got req=%b expected 1", bus_request);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        m_req   = 2'b11;
        bus_ack = 1'b1;
        @(negedge clk);
        #1;
        n_asserts++;
        if ({bus_request, m_gnt} !== 3'b100) begin
            n_fail++;
            $display("FAIL rr_request: got req=%b gnt=%b, expected req=1 gnt=00", bus_request, m_gnt);
        end
        @(negedge clk);
        #1;
        n_asserts++;
        if ({m_gnt, bus_request} !== 3'b011) begin
            n_fail++;
            $display("FAIL rr_first: got gnt=%b req=%b, expected gnt=01 req=1", m_gnt, bus_request);
        end
        m_req          = 2'b10;
        m_read         = 2'b11;
        m_write        = 2'b11;
        m_bus_status   = 4'hF;
        cpu_read       = 1'b1;
        cpu_write      = 1'b1;
        cpu_bus_status = 2'b11;
        @(negedge clk);
        #1;
        n_asserts++;
        if ({m_gnt, owner, read, write, bus_status, bus_request} !== {2'b00, 2'd3, 1'b0, 1'b0, BI, 1'b1}) begin
            n_fail++;
            $display("FAIL rr_turn: got gnt=%b own=%0d rd=%b wr=%b st=%b req=%b, expected 00/3/0/0/%b/1",
                     m_gnt, owner, read, write, bus_status, bus_request, BI);
        end
        @(negedge clk);
        #1;
        n_asserts++;
        if ({m_gnt, owner, address_out, bus_request} !== {2'b10, 2'd2, m_address[47:24], 1'b1}) begin
            n_fail++;
            $display("FAIL rr_second: got gnt=%b own=%0d addr=%h req=%b, expected 10/2/%h/1",
                     m_gnt, owner, address_out, bus_request, m_address[47:24]);
        end
        m_req = 2'b11;
        @(negedge clk);
        m_req = 2'b01;
        @(negedge clk);
        #1;
        n_asserts++;
        if ({owner, bus_request} !== {2'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL rr_turn2: got own=%0d req=%b, expected own=3 req=1", owner, bus_request);
        end
        @(negedge clk);
        #1;
        n_asserts++;
        if (m_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_back_to_m0: got gnt=%b expected 01", m_gnt);
        end
    endtask

    task automatic test_drop_before_service();
        do_reset();
        m_req   = 2'b11;
        bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        m_req = 2'b01;
        @(negedge clk);
        m_req = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        n_asserts++;
        if ({m_gnt, bus_request, owner} !== 5'b0) begin
            n_fail++;
            $display("FAIL drop_no_grant: got gnt=%b req=%b own=%0d, expected 00/0/0", m_gnt, bus_request, owner);
        end
    endtask

    task automatic test_hold_timeout();
        do_reset();
        m_req   = 2'b01;
        bus_ack = 1'b1;
        repeat (2) @(negedge clk);          // first GRANT cycle
        repeat (MAXH - 2) @(negedge clk);   // GRANT cycle MAXH-1
        #1;
        n_asserts++;
        if ({hold_timeout, m_gnt} !== 3'b001) begin
            n_fail++;
            $display("FAIL hold_before: got to=%b gnt=%b, expected to=0 gnt=01", hold_timeout, m_gnt);
        end
        @(negedge clk);                     // GRANT cycle MAXH
        #1;
        n_asserts++;
        if ({hold_timeout, m_gnt} !== 3'b101) begin
            n_fail++;
            $display("FAIL hold_at_max: got to=%b gnt=%b, expected to=1 gnt=01", hold_timeout, m_gnt);
        end
        repeat (5) @(negedge clk);
        #1;
        n_asserts++;
        if ({hold_timeout, m_gnt} !== 3'b101) begin
            n_fail++;
            $display("FAIL hold_retained: got to=%b gnt=%b, expected to=1 gnt=01", hold_timeout, m_gnt);
        end
        m_req = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        n_asserts++;
        if (hold_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_sticky: got %b expected 1", hold_timeout);
        end
    endtask

    task automatic test_protocol_error();
        do_reset();
        m_req   = 2'b10;
        bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_asserts++;
        if ({m_gnt, protocol_error} !== 3'b100) begin
            n_fail++;
            $display("FAIL perr_grant: got gnt=%b pe=%b, expected gnt=10 pe=0", m_gnt, protocol_error);
        end
        bus_ack = 1'b0;
        @(negedge clk);
        #1;
        n_asserts++;
        if ({m_gnt, protocol_error, owner} !== {2'b00, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL perr_flag: got gnt=%b pe=%b own=%0d, expected 00/1/0", m_gnt, protocol_error, owner);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        m_req   = 2'b01;
        bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_asserts++;
        if (m_gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL areset_pre: got gnt=%b expected 01", m_gnt);
        end
        #2;
        reset = 1'b0;
        #1;
        n_asserts++;
        if ({m_gnt, bus_request, owner, address_out} !== {2'b00, 1'b0, 2'd0, cpu_address}) begin
            n_fail++;
            $display("FAIL areset_immediate: got gnt=%b req=%b own=%0d addr=%h, expected 00/0/0/%h",
                     m_gnt, bus_request, owner, address_out, cpu_address);
        end
    endtask

    // Behavioural model: who owns the bus, how many turnaround cycles remain,
    // whether we are holding the CPU off or waiting for it to take the bus back.
    task automatic test_random();
        int          own    = -1;
        int          turn   = 0;
        int          last   = 1;
        int          hold   = 0;
        int          g;
        bit          hreq   = 1'b0;
        bit          rel    = 1'b0;
        bit          to     = 1'b0;
        bit          pe     = 1'b0;
        logic [4:0]  exp_ctl;
        logic [35:0] exp_bus;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!m_req[i]) begin
                    if ($urandom_range(0, 3) == 0) m_req[i] = 1'b1;
                end else if ($urandom_range(0, 7) == 0) begin
                    m_req[i] = 1'b0;
                end
            end
            if (bus_request && !bus_ack && $urandom_range(0, 2) == 0) bus_ack = 1'b1;
            else if (!bus_request && bus_ack && $urandom_range(0, 2) == 0) bus_ack = 1'b0;
            else if (bus_request && bus_ack && $urandom_range(0, 149) == 0) bus_ack = 1'b0;
            rand_bus();
            #1;
            exp_ctl[4:3] = (own >= 0 && bus_ack) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
            exp_ctl[2]   = hreq;
            exp_ctl[1:0] = (own >= 0) ? 2'(own + 1) : ((turn > 0) ? 2'd3 : 2'd0);
            n_asserts++;
            if ({m_gnt, bus_request, owner} !== exp_ctl) begin
                n_fail++;
                $display("FAIL rand_ctl cyc%0d: got gnt/req/own=%b, expected %b", cyc,
                         {m_gnt, bus_request, owner}, exp_ctl);
            end
            if (turn > 0) begin
                n_asserts++;
                if ({read, write, bus_status} !== {2'b00, BI}) begin
                    n_fail++;
                    $display("FAIL rand_turn_bus cyc%0d: got rd/wr/st=%b, expected %b", cyc,
                             {read, write, bus_status}, {2'b00, BI});
                end
            end else begin
                if (own == 0)
                    exp_bus = {m_address[23:0], m_data_out[7:0], m_read[0], m_write[0], m_bus_status[1:0]};
                else if (own == 1)
                    exp_bus = {m_address[47:24], m_data_out[15:8], m_read[1], m_write[1], m_bus_status[3:2]};
                else
                    exp_bus = {cpu_address, cpu_data_out, cpu_read, cpu_write, cpu_bus_status};
                n_asserts++;
                if ({address_out, data_out, read, write, bus_status} !== exp_bus) begin
                    n_fail++;
                    $display("FAIL rand_bus cyc%0d: got %h, expected %h", cyc,
                             {address_out, data_out, read, write, bus_status}, exp_bus);
                end
            end
            n_asserts++;
            if ({hold_timeout, protocol_error} !== {to, pe}) begin
                n_fail++;
                $display("FAIL rand_flags cyc%0d: got to/pe=%b%b, expected %b%b", cyc,
                         hold_timeout, protocol_error, to, pe);
            end
            // Advance the model with the inputs the coming rising edge will see.
            g = -1;
            if (own >= 0) begin
                if (!bus_ack) begin
                    own = -1; hreq = 1'b0; pe = 1'b1;
                end else if (!m_req[own]) begin
                    last = own; own = -1;
                    if (TA > 0) turn = TA;
                    else if (m_req[1 - last]) g = 1 - last;
                    else begin hreq = 1'b0; rel = 1'b1; end
                end else begin
                    if (hold < 65535) hold++;
                    if (hold >= MAXH) to = 1'b1;
                end
            end else if (turn > 0) begin
                if (!bus_ack) begin
                    turn = 0; hreq = 1'b0; pe = 1'b1;
                end else begin
                    turn--;
                    if (turn == 0) begin
                        if (m_req[1 - last]) g = 1 - last;
                        else begin hreq = 1'b0; rel = 1'b1; end
                    end
                end
            end else if (rel) begin
                if (!bus_ack) rel = 1'b0;
            end else if (hreq) begin
                if (m_req == 2'b00) begin hreq = 1'b0; rel = 1'b1; end
                else if (bus_ack) g = (m_req == 2'b11) ? (1 - last) : (m_req[1] ? 1 : 0);
            end else if (m_req != 2'b00) begin
                hreq = 1'b1;
            end
            if (g >= 0) begin
                own = g; last = g; hold = 1;
                if (hold >= MAXH) to = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        m_req = 2'b00;
        bus_ack = 1'b0;
        rand_bus();
        test_reset();
        test_single_grant();
        test_round_robin();
        test_drop_before_service();
        test_hold_timeout();
        test_protocol_error();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
